pe_grant_sequencer: RTL and testbench

PE_GRANT_SEQUENCER -- requirements
Module: pe_grant_sequencer

---
 rtl/pe_pkg.sv | 15 +
 rtl/prio_enc64.sv | 24 ++
 rtl/pe_grant_sequencer.sv | 132 +++++++++++++
 tb/tb_pe_grant_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// pe_pkg: shared constants and FSM state type for the grant sequencer.
//   NUM_REQ    - number of request lines (64 is the only supported value)
//   IDX_W      - grant index width, log2(NUM_REQ)
//   pe_state_t - grant FSM state: IDLE (no offer) / OFFER (grant offered)
package pe_pkg;

    localparam int NUM_REQ = 64;
    localparam int IDX_W   = 6;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } pe_state_t;

endpackage

// File: rtl/prio_enc64.sv
// prio_enc64: combinational 64-to-6 highest-index priority encoder.
// Ports:
//   vec [63:0] - candidate bits
//   idx [5:0]  - index of the highest set bit in vec (0 when none set)
//   any        - high when at least one bit of vec is set
module prio_enc64 (
    input  logic [pe_pkg::NUM_REQ-1:0] vec,
    output logic [pe_pkg::IDX_W-1:0]   idx,
    output logic                       any
);

    // Ascending scan: the last set bit seen is the highest index, so it wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = 0; i < pe_pkg::NUM_REQ; i++) begin
            if (vec[i]) begin
                idx = pe_pkg::IDX_W'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pe_grant_sequencer.sv
// pe_grant_sequencer: collects request pulses into a pending vector and
// offers them one at a time, highest eligible index first.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   req_i        - per-cycle request pulses; bit k sets pending[k]
//   mask_i       - eligibility mask applied to pending
//   en_i         - allows loading a new grant; pending accumulates regardless
//   flush_i      - clears pending and any offered grant on the next edge
//   gnt_valid_o  - grant offer valid
//   gnt_idx_o    - index of the offered request (63 = highest priority)
//   gnt_ready_i  - consumer accept
//   pend_cnt_o   - registered population count of pending (0..64)
//   merge_cnt_o  - saturating count of pulses that hit an already-pending bit
//   dbg_state_o  - current FSM state (0 = IDLE, 1 = OFFER)
//
// Handshake: an offer transfers on a rising edge where gnt_valid_o and
// gnt_ready_i are both high. While gnt_valid_o is high without gnt_ready_i,
// gnt_idx_o is held stable; the offer is only withdrawn by flush_i or reset.
module pe_grant_sequencer #(
    parameter int NUM_REQ = pe_pkg::NUM_REQ,
    parameter int IDX_W   = pe_pkg::IDX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [NUM_REQ-1:0] mask_i,
    input  logic               en_i,
    input  logic               flush_i,
    output logic               gnt_valid_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    input  logic               gnt_ready_i,
    output logic [IDX_W:0]     pend_cnt_o,
    output logic [7:0]         merge_cnt_o,
    output logic               dbg_state_o
);

    import pe_pkg::*;

    pe_state_t          state_q, state_d;
    logic [NUM_REQ-1:0] pend_q, pend_d;
    logic [NUM_REQ-1:0] elig, clr_vec, hit_vec;
    logic [IDX_W-1:0]   idx_q, idx_d, sel_idx;
    logic               sel_any, load;
    logic [IDX_W:0]     pend_cnt_q, hit_cnt;
    logic [7:0]         merge_q, merge_d;
    logic [8:0]         merge_sum;

    function automatic logic [IDX_W:0] popcount(input logic [NUM_REQ-1:0] v);
        logic [IDX_W:0] c;
        c = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            c = c + (IDX_W+1)'(v[i]);
        end
        return c;
    endfunction

    assign elig = pend_q & mask_i;

    prio_enc64 u_prio (
        .vec (elig),
        .idx (sel_idx),
        .any (sel_any)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        load    = 1'b0;

        case (state_q)
            IDLE: begin
                if (en_i && sel_any) load = 1'b1;
            end
            OFFER: begin
                // Back-to-back: a completed handshake may reload in the same edge.
                if (gnt_ready_i) begin
                    if (en_i && sel_any) load = 1'b1;
                    else                 state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d = OFFER;
            idx_d   = sel_idx;
        end

        clr_vec = '0;
        if (load) clr_vec[sel_idx] = 1'b1;

        // A new pulse on the bit being granted re-arms it (set wins over clear);
        // only pulses onto bits that remain pending count as merges.
        hit_vec = req_i & pend_q & ~clr_vec;
        pend_d  = (pend_q & ~clr_vec) | req_i;

        hit_cnt   = popcount(hit_vec);
        merge_sum = {1'b0, merge_q} + {2'b00, hit_cnt};
        merge_d   = (merge_sum > 9'd255) ? 8'hFF : merge_sum[7:0];

        // Flush drops everything in flight, including this cycle's pulses.
        if (flush_i) begin
            state_d = IDLE;
            idx_d   = idx_q;
            pend_d  = '0;
            merge_d = merge_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            pend_q     <= '0;
            pend_cnt_q <= '0;
            merge_q    <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            pend_cnt_q <= popcount(pend_d);
            merge_q    <= merge_d;
        end
    end

    assign gnt_valid_o = (state_q == OFFER);
    assign gnt_idx_o   = idx_q;
    assign pend_cnt_o  = pend_cnt_q;
    assign merge_cnt_o = merge_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_pe_grant_sequencer.sv
// Directed bench for pe_grant_sequencer. Expected grant indices are queued
// when requests are issued; a negedge monitor pops one entry per accepted
// offer (gnt_valid_o && gnt_ready_i). Inputs change 1 ns after the rising
// edge; cycle-specific values are checked at that point too.
module tb_pe_grant_sequencer;

  import pe_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [63:0] req_i;
  logic [63:0] mask_i;
  logic        en_i;
  logic        flush_i;
  logic        gnt_valid_o;
  logic [5:0]  gnt_idx_o;
  logic        gnt_ready_i;
  logic [6:0]  pend_cnt_o;
  logic [7:0]  merge_cnt_o;
  logic        dbg_state_o;

  logic [5:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  pe_grant_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .mask_i      (mask_i),
    .en_i        (en_i),
    .flush_i     (flush_i),
    .gnt_valid_o (gnt_valid_o),
    .gnt_idx_o   (gnt_idx_o),
    .gnt_ready_i (gnt_ready_i),
    .pend_cnt_o  (pend_cnt_o),
    .merge_cnt_o (merge_cnt_o),
    .dbg_state_o (dbg_state_o)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver helpers
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] bit64(input int k);
    logic [63:0] v;
    v = 64'd1 << k;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && gnt_valid_o && gnt_ready_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL grant_unexpected: got idx %0d expected no grant", gnt_idx_o);
      end else begin
        check("grant_idx", 64'(gnt_idx_o), 64'(exp_q.pop_front()));
      end
    end
  end

  // stimulus
  initial begin
    rst_n       = 1'b0;
    req_i       = '0;
    mask_i      = '1;
    en_i        = 1'b1;
    flush_i     = 1'b0;
    gnt_ready_i = 1'b1;
    repeat (3) cyc();
    check("rst_valid", gnt_valid_o, 0);
    check("rst_idx",   gnt_idx_o,   0);
    check("rst_pend",  pend_cnt_o,  0);
    check("rst_merge", merge_cnt_o, 0);
    rst_n = 1'b1;
    cyc();

    // single request latency: pulse in cycle 0, offer in cycle 2
    exp_q.push_back(6'd5);
    req_i = bit64(5);
    cyc();
    req_i = '0;
    check("t1_c1_valid", gnt_valid_o, 0);
    check("t1_c1_pend",  pend_cnt_o,  1);
    cyc();
    check("t1_c2_valid", gnt_valid_o, 1);
    check("t1_c2_idx",   gnt_idx_o,   5);
    check("t1_c2_state", dbg_state_o, 1);
    check("t1_c2_pend",  pend_cnt_o,  0);
    cyc();
    check("t1_c3_valid", gnt_valid_o, 0);
    check("t1_c3_state", dbg_state_o, 0);

    // all 64 requests: grants 63..0 back to back, count falls 64..0
    for (int i = 63; i >= 0; i--) exp_q.push_back(6'(i));
    req_i = '1;
    cyc();
    req_i = '0;
    check("t2_c1_valid", gnt_valid_o, 0);
    check("t2_c1_pend",  pend_cnt_o,  64);
    for (int k = 2; k <= 65; k++) begin
      cyc();
      check("t2_valid", gnt_valid_o, 1);
      check("t2_pend",  pend_cnt_o,  65 - k);
    end
    cyc();
    check("t2_end_valid", gnt_valid_o, 0);

    // offer held under backpressure and mask removal, then back-to-back 40
    gnt_ready_i = 1'b0;
    exp_q.push_back(6'd10);
    req_i = bit64(10);
    cyc();
    req_i = '0;
    cyc();
    check("t3_c2_valid", gnt_valid_o, 1);
    check("t3_c2_idx",   gnt_idx_o,   10);
    req_i  = bit64(40);
    mask_i = ~bit64(10);
    for (int k = 0; k < 5; k++) begin
      cyc();
      req_i = '0;
      check("t3_hold_valid", gnt_valid_o, 1);
      check("t3_hold_idx",   gnt_idx_o,   10);
    end
    exp_q.push_back(6'd40);
    mask_i      = '1;
    gnt_ready_i = 1'b1;
    cyc();
    check("t3_next_valid", gnt_valid_o, 1);
    check("t3_next_idx",   gnt_idx_o,   40);
    cyc();
    check("t3_end_valid", gnt_valid_o, 0);

    // merge saturation with grants disabled, then exactly one grant of 7
    en_i  = 1'b0;
    req_i = bit64(7);
    cyc();
    for (int n = 1; n <= 300; n++) begin
      cyc();
      if (n == 100) check("t4_merge_100", merge_cnt_o, 100);
    end
    req_i = '0;
    check("t4_merge_sat", merge_cnt_o, 255);
    check("t4_pend",      pend_cnt_o,  1);
    check("t4_en_valid",  gnt_valid_o, 0);
    exp_q.push_back(6'd7);
    en_i = 1'b1;
    cyc();
    check("t4_gnt_valid", gnt_valid_o, 1);
    check("t4_gnt_idx",   gnt_idx_o,   7);
    cyc();
    cyc();
    check("t4_end_valid", gnt_valid_o, 0);
    check("t4_end_pend",  pend_cnt_o,  0);

    // masked bit waits until eligible
    mask_i = ~bit64(20);
    req_i  = bit64(20) | bit64(3);
    exp_q.push_back(6'd3);
    cyc();
    req_i = '0;
    cyc();
    check("t5_idx3", gnt_idx_o, 3);
    cyc();
    cyc();
    check("t5_masked_valid", gnt_valid_o, 0);
    check("t5_masked_pend",  pend_cnt_o,  1);
    exp_q.push_back(6'd20);
    mask_i = '1;
    cyc();
    check("t5_unmask_valid", gnt_valid_o, 1);
    check("t5_unmask_idx",   gnt_idx_o,   20);
    cyc();
    check("t5_end_valid", gnt_valid_o, 0);
    check("t5_end_pend",  pend_cnt_o,  0);

    // flush during an offer with 12 pending; same-cycle request discarded
    gnt_ready_i = 1'b0;
    req_i = 64'h0000_0000_0000_1FFF;
    cyc();
    req_i = '0;
    cyc();
    check("t6_offer_valid", gnt_valid_o, 1);
    check("t6_offer_idx",   gnt_idx_o,   12);
    check("t6_offer_pend",  pend_cnt_o,  12);
    flush_i = 1'b1;
    req_i   = bit64(50);
    cyc();
    flush_i = 1'b0;
    req_i   = '0;
    check("t6_flush_valid", gnt_valid_o, 0);
    check("t6_flush_pend",  pend_cnt_o,  0);
    check("t6_flush_state", dbg_state_o, 0);
    check("t6_flush_merge", merge_cnt_o, 255);
    cyc();
    cyc();
    check("t6_post_valid", gnt_valid_o, 0);
    check("t6_post_pend",  pend_cnt_o,  0);

    // reset mid-offer drops the offer without a handshake
    req_i = bit64(30);
    cyc();
    req_i = '0;
    cyc();
    check("t7_offer_valid", gnt_valid_o, 1);
    check("t7_offer_idx",   gnt_idx_o,   30);
    rst_n = 1'b0;
    cyc();
    check("t7_rst_valid", gnt_valid_o, 0);
    check("t7_rst_pend",  pend_cnt_o,  0);
    check("t7_rst_idx",   gnt_idx_o,   0);
    check("t7_rst_merge", merge_cnt_o, 0);
    rst_n       = 1'b1;
    gnt_ready_i = 1'b1;
    cyc();
    cyc();
    check("t7_post_valid", gnt_valid_o, 0);

    check("exp_q_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
